ov5640_sccb_ctrl: RTL and testbench
===================================

Name: ov5640_sccb_ctrl

Overview:
- SCCB (I2C-compatible) write master that executes one OV5640 register write per request from the register-sequencing ROM.
- Accepts `cfg_start` pulse + 24-bit `{reg_addr[15:0], reg_val[7:0]}`.
- Emits START, device-ID byte, address high byte, address low byte, data byte, STOP on an open-drain SCL/SDA pair.
- Pulses `cfg_end` on completion so the sequencer advances to the next entry.

Parameters:
- SYS_CLK_FREQ, 50_000_000, sys_clk frequency in Hz
- SCL_FREQ, 250_000, SCL frequency in Hz
- DEVICE_ID, 8'h78, 8-bit SCCB write address (R/W bit = 0 included)
- MAX_RETRY, 3, retries after NACK (used only with SCCB_ACK_CHECK_EN)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous reset, active-high
- cfg_start  in  1  single-cycle write request
- cfg_data  in  24  {reg_addr[15:0], reg_val[7:0]}, sampled on cfg_start
- cfg_end  out  1  single-cycle pulse, write complete
- busy  out  1  high from accepted cfg_start until cfg_end
- scl  out  1  SCCB clock (push-pull, idle high)
- sda_o  out  1  SDA drive value (always 0 when driving)
- sda_oe  out  1  SDA output enable; 0 = released (pulled high)
- sda_i  in  1  SDA pad input
- ack_err  out  1  sticky NACK/abort flag

Behaviour:
- **Reset values:** scl=1, sda_o=0, sda_oe=0, cfg_end=0, busy=0, ack_err=0, state=IDLE, all counters 0.
- **Quarter tick:** Q = SYS_CLK_FREQ/(4*SCL_FREQ) cycles (50 at defaults). The tick counter runs only while busy and reloads to 0 on acceptance.
- **Request acceptance:**
  - cfg_start in IDLE latches cfg_data and sets busy next cycle.
  - cfg_start while busy is ignored; the latched data is unchanged.
- **States:** IDLE → START → BYTE → ACK → (BYTE | STOP) → DONE → IDLE.
  - Byte index 0..3 selects DEVICE_ID, addr[15:8], addr[7:0], val.
  - Bit counter runs 7..0, MSB first.
- **START (4 quarters):**
  - q0–q1: SDA released, SCL=1.
  - q2: SDA driven low.
  - q3: SCL=0.
- **BYTE bit (4 quarters):**
  - q0: SCL=0, SDA set (bit 0 → sda_oe=1, bit 1 → sda_oe=0).
  - q1: SCL=0.
  - q2–q3: SCL=1.
- **ACK bit:** same timing as a data bit, with SDA released. sda_i is sampled at the first cycle of q3.
- **STOP (4 quarters):**
  - q0: SCL=0, SDA driven low.
  - q1–q2: SCL=1.
  - q3: SDA released.
- **DONE:** one cycle. cfg_end=1, busy drops to 0 in the same cycle, return to IDLE.
- **Latency:** START 4 + 4 bytes × 9 bits × 4 + STOP 4 = 152 quarters = 7600 sys_clk at defaults. cfg_end asserts exactly 1 cycle after the final STOP quarter.
- **Back-to-back:** cfg_start in the cycle after cfg_end is accepted, since IDLE is reached on that cycle.
- **Reset mid-transfer:** outputs return to reset values immediately (asynchronous), bus released, no cfg_end.
- **ack_err:** cleared only by reset or by an accepted cfg_start.

Optional Feature:
- Macro: **SCCB_ACK_CHECK_EN**.
- **Defined:**
  - sda_i=1 sampled in ACK is a NACK. It sets ack_err, skips remaining bytes, and goes to STOP.
  - After STOP, if retry_cnt < MAX_RETRY: increment retry_cnt and restart at START with the same latched data, without pulsing cfg_end.
  - Otherwise go to DONE (cfg_end pulses, ack_err stays 1).
  - retry_cnt clears on acceptance.
- **Undefined:** ACK sample is ignored (SCCB don't-care bit), ack_err is tied 0, and there is no retry logic.

Decomposition:
- **Package ov5640_pkg:**
  - state enum: IDLE, START, BYTE, ACK, STOP, DONE
  - 2-bit quarter index type
  - DEFAULT_DEVICE_ID = 8'h78
  - byte-index constants
- **Sub-module sccb_tick_gen:**
  - Inputs: sys_clk, sys_rst, en.
  - Parameters: SYS_CLK_FREQ, SCL_FREQ.
  - Outputs: a 1-cycle tick every Q cycles and a 2-bit quarter index.
  - Resets its count when en=0.

Test Plan:
1. **Single write, defaults:** cfg_start with cfg_data=24'h300882, slave model ACKs → SCL shows 36 rising edges between START and STOP. SDA bytes are 78,30,08,82. cfg_end pulses at cycle 7601 after cfg_start. busy=0 after.
2. **Back-to-back:** cfg_start=24'h3103_03 issued in the cycle after cfg_end of a prior write → accepted, second transfer bytes 78,31,03,03, second cfg_end 7601 cycles later.
3. **Ignored request:** cfg_start=24'h3017ff at cycle 1000 of an active write of 24'h300842 → bus bytes remain 78,30,08,42. Exactly one cfg_end.
4. **Async reset:** assert sys_rst at cycle 3000 of a transfer → scl=1, sda_oe=0, busy=0 within the same cycle. No cfg_end. The next cfg_start completes normally.
5. **NACK with SCCB_ACK_CHECK_EN, MAX_RETRY=3:** slave NACKs DEVICE_ID always → 4 attempts (START…STOP each), ack_err=1, single cfg_end after the 4th STOP.
6. **NACK without SCCB_ACK_CHECK_EN:** slave NACKs all bytes → full 152-quarter transfer, ack_err=0, cfg_end at cycle 7601.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        ACK,
        STOP,
        DONE
    } sccb_state_t;

    typedef logic [1:0] quarter_t;

    localparam quarter_t QTR_0 = 2'd0;
    localparam quarter_t QTR_1 = 2'd1;
    localparam quarter_t QTR_2 = 2'd2;
    localparam quarter_t QTR_3 = 2'd3;

    localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h78;

    localparam logic [1:0] BYTE_DEV     = 2'd0;
    localparam logic [1:0] BYTE_ADDR_HI = 2'd1;
    localparam logic [1:0] BYTE_ADDR_LO = 2'd2;
    localparam logic [1:0] BYTE_VAL     = 2'd3;

    // Byte on the wire for a given index of the 4-byte register write.
    function automatic logic [7:0] sccb_byte(input logic [7:0]  dev_id,
                                             input logic [23:0] data,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            BYTE_DEV:     b = dev_id;
            BYTE_ADDR_HI: b = data[23:16];
            BYTE_ADDR_LO: b = data[15:8];
            default:      b = data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ov5640_sccb_ctrl_tick_gen.sv
// Quarter-SCL-period tick generator; count and quarter index clear while en=0.
module sccb_tick_gen
    import ov5640_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned SCL_FREQ     = 250_000
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    input  logic     en,
    output logic     tick,
    output quarter_t quarter,
    output logic     q_first
);

    localparam int unsigned Q     = (SYS_CLK_FREQ / (4 * SCL_FREQ) > 0) ?
                                    SYS_CLK_FREQ / (4 * SCL_FREQ) : 1;
    localparam int unsigned CNT_W = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Q - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt     <= '0;
            quarter <= QTR_0;
        end else if (!en) begin
            cnt     <= '0;
            quarter <= QTR_0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick    = en && (cnt == LAST);
    assign q_first = en && (cnt == '0);

endmodule

// File: rtl/ov5640_sccb_ctrl.sv
// SCCB write master: one 3-phase OV5640 register write per cfg_start.
// Optional macro SCCB_ACK_CHECK_EN enables NACK detection, ack_err and retries.
module ov5640_sccb_ctrl
    import ov5640_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned SCL_FREQ     = 250_000,
    parameter logic [7:0]  DEVICE_ID    = DEFAULT_DEVICE_ID,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        scl,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic        ack_err
);

    sccb_state_t state, state_nxt;
    logic [23:0] data_q, data_nxt;
    logic [1:0]  byte_idx, byte_nxt;
    logic [2:0]  bit_idx, bit_nxt;

    logic        tick, q_first, last_q, cur_bit;
    quarter_t    quarter;
    logic [7:0]  cur_byte;
    logic        unused_ok;

`ifdef SCCB_ACK_CHECK_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic               nack_q, nack_nxt;
    logic               ack_err_q, err_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
`endif

    sccb_tick_gen #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .SCL_FREQ     (SCL_FREQ)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (busy),
        .tick    (tick),
        .quarter (quarter),
        .q_first (q_first)
    );

    assign last_q   = tick && (quarter == QTR_3);
    assign cur_byte = sccb_byte(DEVICE_ID, data_q, byte_idx);
    assign cur_bit  = cur_byte[bit_idx];

    assign busy    = (state == START) || (state == BYTE) ||
                     (state == ACK)   || (state == STOP);
    assign cfg_end = (state == DONE);
    assign sda_o   = 1'b0;
    assign unused_ok = sda_i ^ (MAX_RETRY == 0);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            data_q    <= '0;
            byte_idx  <= BYTE_DEV;
            bit_idx   <= '0;
`ifdef SCCB_ACK_CHECK_EN
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            retry_cnt <= '0;
`endif
        end else begin
            state     <= state_nxt;
            data_q    <= data_nxt;
            byte_idx  <= byte_nxt;
            bit_idx   <= bit_nxt;
`ifdef SCCB_ACK_CHECK_EN
            nack_q    <= nack_nxt;
            ack_err_q <= err_nxt;
            retry_cnt <= retry_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        byte_nxt  = byte_idx;
        bit_nxt   = bit_idx;
`ifdef SCCB_ACK_CHECK_EN
        nack_nxt  = nack_q;
        err_nxt   = ack_err_q;
        retry_nxt = retry_cnt;
`endif
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = START;
                    data_nxt  = cfg_data;
`ifdef SCCB_ACK_CHECK_EN
                    nack_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    retry_nxt = '0;
`endif
                end
            end
            START: begin
                if (last_q) begin
                    state_nxt = BYTE;
                    byte_nxt  = BYTE_DEV;
                    bit_nxt   = 3'd7;
`ifdef SCCB_ACK_CHECK_EN
                    nack_nxt  = 1'b0;
`endif
                end
            end
            BYTE: begin
                if (last_q) begin
                    if (bit_idx == 3'd0) state_nxt = ACK;
                    else                 bit_nxt   = bit_idx - 3'd1;
                end
            end
            ACK: begin
`ifdef SCCB_ACK_CHECK_EN
                if (q_first && (quarter == QTR_3) && sda_i) begin
                    nack_nxt = 1'b1;
                    err_nxt  = 1'b1;
                end
                if (last_q) begin
                    if ((byte_idx == BYTE_VAL) || nack_nxt) begin
                        state_nxt = STOP;
                    end else begin
                        state_nxt = BYTE;
                        byte_nxt  = byte_idx + 2'd1;
                        bit_nxt   = 3'd7;
                    end
                end
`else
                if (last_q) begin
                    if (byte_idx == BYTE_VAL) begin
                        state_nxt = STOP;
                    end else begin
                        state_nxt = BYTE;
                        byte_nxt  = byte_idx + 2'd1;
                        bit_nxt   = 3'd7;
                    end
                end
`endif
            end
            STOP: begin
                if (last_q) begin
`ifdef SCCB_ACK_CHECK_EN
                    // NACKed attempts restart from START with the latched data; no cfg_end.
                    if (nack_q && (retry_cnt < RETRY_W'(MAX_RETRY))) begin
                        state_nxt = START;
                        retry_nxt = retry_cnt + 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state)
            START: begin
                scl    = (quarter != QTR_3);
                sda_oe = quarter[1];
            end
            BYTE: begin
                scl    = quarter[1];
                sda_oe = ~cur_bit;
            end
            ACK: begin
                scl    = quarter[1];
            end
            STOP: begin
                scl    = (quarter != QTR_0);
                sda_oe = (quarter != QTR_3);
            end
            default: ;
        endcase
    end

`ifdef SCCB_ACK_CHECK_EN
    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_sccb_ctrl.sv
// Scoreboard bench for ov5640_sccb_ctrl: bus monitor decodes SDA bytes and checks cfg_end timing.
module tb_ov5640_sccb_ctrl;

    localparam int LAT     = 7601;
    localparam int LAT_NAK = 8801;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [23:0] cfg_data = '0;
    logic        cfg_end, busy, scl, sda_o, sda_oe, ack_err, sda_i, sda_line;
    logic        slave_pull = 1'b0;
    logic        slave_nack = 1'b0;

    assign sda_line = (sda_oe ? sda_o : 1'b1) & ~slave_pull;
    assign sda_i    = sda_line;

    ov5640_sccb_ctrl #(
        .SYS_CLK_FREQ (50_000_000),
        .SCL_FREQ     (250_000),
        .DEVICE_ID    (8'h78),
        .MAX_RETRY    (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start),
        .cfg_data  (cfg_data),
        .cfg_end   (cfg_end),
        .busy      (busy),
        .scl       (scl),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .ack_err   (ack_err)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] byte_q[$];
    int         pulse_q[$];
    int         end_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Bus monitor + ACKing slave model
    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_xfer = 1'b0, rose = 1'b0;
    int         bitcnt = 0, pulses = 0;
    logic [7:0] sh = '0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            in_xfer = 1'b0; slave_pull = 1'b0; bitcnt = 0; rose = 1'b0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (cfg_end) begin
                if (end_q.size() == 0) flag_fail("unexpected_cfg_end");
                else begin
                    check("cfg_end_cycle", cyc, end_q.pop_front());
                    check("busy_at_cfg_end", {31'd0, busy}, 32'd0);
                end
            end
            if (scl && prev_scl && prev_sda && !sda_line) begin
                in_xfer = 1'b1; bitcnt = 0; pulses = 0; rose = 1'b0;
            end else if (in_xfer && scl && prev_scl && !prev_sda && sda_line) begin
                in_xfer = 1'b0;
                if (pulse_q.size() == 0) flag_fail("unexpected_stop");
                else check("scl_pulses", pulses, pulse_q.pop_front());
            end else if (in_xfer && scl && !prev_scl) begin
                rose = 1'b1;
                if (bitcnt < 8) begin
                    sh = {sh[6:0], sda_line};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (byte_q.size() == 0) flag_fail("unexpected_byte");
                        else check("sda_byte", {24'd0, sh}, {24'd0, byte_q.pop_front()});
                    end
                end else begin
                    bitcnt = 0;
                end
            end else if (in_xfer && !scl && prev_scl) begin
                if (rose) pulses++;
                rose = 1'b0;
                slave_pull = (bitcnt == 8) && !slave_nack;
            end
            prev_scl = scl;
            prev_sda = sda_line;
        end
    end

    task automatic push_write(input logic [23:0] d);
        byte_q.push_back(8'h78);
        byte_q.push_back(d[23:16]);
        byte_q.push_back(d[15:8]);
        byte_q.push_back(d[7:0]);
        pulse_q.push_back(36);
    endtask

    task automatic issue(input logic [23:0] d, output int t0);
        @(posedge sys_clk); #1;
        cfg_data  = d;
        cfg_start = 1'b1;
        t0 = cyc;
        @(posedge sys_clk); #1;
        cfg_start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_end(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge sys_clk); #1;
            if (cfg_end) got = 1'b1;
        end
        if (!got) flag_fail("cfg_end_timeout");
    endtask

    initial begin
        int t0;
        repeat (5) @(posedge sys_clk);
        #1;
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_sda_o", {31'd0, sda_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cfg_end", {31'd0, cfg_end}, 32'd0);
        check("rst_ack_err", {31'd0, ack_err}, 32'd0);
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);

        // Single write
        push_write(24'h300882);
        issue(24'h300882, t0);
        end_q.push_back(t0 + LAT);
        wait_end(9000);

        // Back-to-back, issued in the cycle after cfg_end
        push_write(24'h310303);
        issue(24'h310303, t0);
        end_q.push_back(t0 + LAT);
        check("busy_b2b", {31'd0, busy}, 32'd1);
        wait_end(9000);
        @(posedge sys_clk); #1;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("ack_err_ok", {31'd0, ack_err}, 32'd0);

        // Request during active write is ignored
        push_write(24'h300842);
        issue(24'h300842, t0);
        end_q.push_back(t0 + LAT);
        repeat (999) @(posedge sys_clk);
        #1;
        cfg_data  = 24'h3017ff;
        cfg_start = 1'b1;
        @(posedge sys_clk); #1;
        cfg_start = 1'b0;
        check("busy_ignored_req", {31'd0, busy}, 32'd1);
        wait_end(9000);
        repeat (200) @(posedge sys_clk);

        // Async reset mid-transfer
        push_write(24'h300811);
        issue(24'h300811, t0);
        end_q.push_back(t0 + LAT);
        repeat (2999) @(posedge sys_clk);
        #5;
        sys_rst = 1'b1;
        #1;
        check("arst_scl", {31'd0, scl}, 32'd1);
        check("arst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cfg_end", {31'd0, cfg_end}, 32'd0);
        byte_q.delete();
        pulse_q.delete();
        end_q.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (100) @(posedge sys_clk);
        push_write(24'h123456);
        issue(24'h123456, t0);
        end_q.push_back(t0 + LAT);
        wait_end(9000);

`ifdef SCCB_ACK_CHECK_EN
        // Permanent NACK: four attempts of the device-ID byte, one cfg_end
        slave_nack = 1'b1;
        for (int a = 0; a < 4; a++) begin
            byte_q.push_back(8'h78);
            pulse_q.push_back(9);
        end
        issue(24'h300a55, t0);
        end_q.push_back(t0 + LAT_NAK);
        wait_end(10000);
        @(posedge sys_clk); #1;
        check("ack_err_nack", {31'd0, ack_err}, 32'd1);
        slave_nack = 1'b0;
        push_write(24'h300a56);
        issue(24'h300a56, t0);
        end_q.push_back(t0 + LAT);
        check("ack_err_cleared", {31'd0, ack_err}, 32'd0);
        wait_end(9000);
`else
        // NACK ignored: full transfer
        slave_nack = 1'b1;
        push_write(24'h300a55);
        issue(24'h300a55, t0);
        end_q.push_back(t0 + LAT);
        wait_end(9000);
        @(posedge sys_clk); #1;
        check("ack_err_tied", {31'd0, ack_err}, 32'd0);
        check("nack_lat_ref", LAT_NAK - LAT, 1200);
        slave_nack = 1'b0;
`endif
        repeat (20) @(posedge sys_clk);
        check("byte_q_drained", byte_q.size(), 0);
        check("pulse_q_drained", pulse_q.size(), 0);
        check("end_q_drained", end_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
